// File: rtl/term_rx_queue_if.sv
// ============================================================================
// Module      : term_rx_queue_if
// Description : Byte-stream input and text-controller command outputs of the
//               terminal receive queue, grouped as one bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface term_rx_queue_if #(
  parameter int DEPTH_LOG2 = 4
);

  // Upstream AXI-Stream byte channel
  logic [7:0]          s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;

  // Downstream text-controller commands
  logic                o_putchar;
  logic                o_clearhome;
  logic [7:0]          o_char;
  logic [DEPTH_LOG2:0] o_level;

  // Side that feeds bytes and observes the commands
  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  o_putchar,
    input  o_clearhome,
    input  o_char,
    input  o_level
  );

  // The queue itself
  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output o_putchar,
    output o_clearhome,
    output o_char,
    output o_level
  );

endinterface

`default_nettype wire

// File: rtl/term_rx_queue.sv
// ============================================================================
// Module      : term_rx_queue
// Description : Buffers UART receive bytes and replays them to the video text
//               controller as paced putchar / clearhome pulses. Form-feed
//               becomes clear-home, NUL bytes are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module term_rx_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CHAR_GAP   = 4096,
  parameter int CLEAR_GAP  = 1048576,
  parameter int GAP_W      = 21
) (
  input  wire logic       i_clk,
  input  wire logic       i_rst,
  term_rx_queue_if.slave  q
);

  localparam int                  DEPTH        = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] c_LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [GAP_W-1:0]    c_CHAR_LOAD  = GAP_W'(CHAR_GAP - 1);
  localparam logic [GAP_W-1:0]    c_CLEAR_LOAD = GAP_W'(CLEAR_GAP - 1);
  localparam logic [GAP_W-1:0]    c_GAP_ONE    = GAP_W'(1);
  localparam logic [7:0]          c_BYTE_FF    = 8'h0C;
  localparam logic [7:0]          c_BYTE_NUL   = 8'h00;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Storage and pointers
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;

  // Output sequencer
  state_t                r_state;
  logic [GAP_W-1:0]      r_gap;
  logic [7:0]            r_char;
  logic                  r_putchar;
  logic                  r_clearhome;

  // Handshake decode
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic [7:0]            w_head;

  // Ready depends only on the registered level, never on tvalid, so a pop
  // in the same cycle as a full queue does not open the door until later.
  assign w_ready = (r_level != c_LEVEL_FULL);
  assign w_push  = q.s_axis_tvalid && w_ready;
  assign w_pop   = (r_state == S_IDLE) && (r_level != '0);
  assign w_head  = r_mem[r_rd_ptr];

  assign q.s_axis_tready = w_ready;
  assign q.o_putchar     = r_putchar;
  assign q.o_clearhome   = r_clearhome;
  assign q.o_char        = r_char;
  assign q.o_level       = r_level;

  // Byte storage: written on accept, contents need no reset
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= q.s_axis_tdata;
    end
  end

  // Circular-buffer pointers and fill level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LEVEL_ONE;
        2'b01:   r_level <= r_level - c_LEVEL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Decode the head byte, emit one-cycle commands and enforce the gap
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_gap       <= '0;
      r_char      <= 8'h00;
      r_putchar   <= 1'b0;
      r_clearhome <= 1'b0;
    end else begin
      r_putchar   <= 1'b0;
      r_clearhome <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_head == c_BYTE_FF) begin
              r_clearhome <= 1'b1;
              r_gap       <= c_CLEAR_LOAD;
              r_state     <= S_WAIT;
            end else if (w_head != c_BYTE_NUL) begin
              r_char      <= w_head;
              r_putchar   <= 1'b1;
              r_gap       <= c_CHAR_LOAD;
              r_state     <= S_WAIT;
            end
            // NUL: consumed silently, the next byte may go on the next edge
          end
        end
        S_WAIT: begin
          if (r_gap == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - c_GAP_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_term_rx_queue.sv
// ============================================================================
// Module      : tb_term_rx_queue
// Description : Self-checking bench for term_rx_queue. A timing-level model
//               (byte queue plus "earliest next issue" edge number) predicts
//               every output; directed scenarios add explicit latency,
//               spacing and ordering checks; a random phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_term_rx_queue;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int CHAR_GAP   = 16;
  localparam int CLEAR_GAP  = 64;
  localparam int GAP_W      = 21;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  term_rx_queue_if #(.DEPTH_LOG2(DEPTH_LOG2)) dif ();

  term_rx_queue #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CHAR_GAP   (CHAR_GAP),
    .CLEAR_GAP  (CLEAR_GAP),
    .GAP_W      (GAP_W)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .q     (dif)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] mq [$];
  int         edge_n  = 0;
  int         free_at = 0;
  logic       m_put   = 1'b0;
  logic       m_clr   = 1'b0;
  logic [7:0] m_char  = 8'h00;

  // Observation records
  int         acc_edge  = -1;
  int         obs_put_edge [$];
  logic [7:0] obs_char [$];
  int         obs_clr_edge [$];
  int         max_level = 0;
  int         stall_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    free_at = 0;
    m_put   = 1'b0;
    m_clr   = 1'b0;
    m_char  = 8'h00;
  endtask

  task automatic clear_obs();
    obs_put_edge.delete();
    obs_char.delete();
    obs_clr_edge.delete();
    max_level = 0;
    stall_cnt = 0;
  endtask

  // One clock: check ready, advance the model across the edge, check outputs
  task automatic step();
    logic       push;
    logic [7:0] d;
    logic [7:0] b;
    chk("tready", 32'(dif.s_axis_tready), 32'(mq.size() != DEPTH));
    push = dif.s_axis_tvalid && (mq.size() != DEPTH);
    if (dif.s_axis_tvalid && !dif.s_axis_tready) stall_cnt++;
    d = dif.s_axis_tdata;
    @(posedge clk);
    edge_n++;
    m_put = 1'b0;
    m_clr = 1'b0;
    if (edge_n >= free_at && mq.size() > 0) begin
      b = mq.pop_front();
      if (b == 8'h0C) begin
        m_clr   = 1'b1;
        free_at = edge_n + CLEAR_GAP + 1;
      end else if (b != 8'h00) begin
        m_put   = 1'b1;
        m_char  = b;
        free_at = edge_n + CHAR_GAP + 1;
      end
    end
    if (push) begin
      mq.push_back(d);
      acc_edge = edge_n;
    end
    #1;
    chk("putchar",   32'(dif.o_putchar),   32'(m_put));
    chk("clearhome", 32'(dif.o_clearhome), 32'(m_clr));
    chk("char",      32'(dif.o_char),      32'(m_char));
    chk("level",     32'(dif.o_level),     32'(mq.size()));
    chk("exclusive", 32'(dif.o_putchar & dif.o_clearhome), 32'(0));
    if (dif.o_putchar === 1'b1) begin
      obs_put_edge.push_back(edge_n);
      obs_char.push_back(dif.o_char);
    end
    if (dif.o_clearhome === 1'b1) obs_clr_edge.push_back(edge_n);
    if (int'(dif.o_level) > max_level) max_level = int'(dif.o_level);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_byte(input logic [7:0] d);
    dif.s_axis_tvalid = 1'b1;
    dif.s_axis_tdata  = d;
    step();
    dif.s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((mq.size() > 0 || edge_n < free_at) && guard < 5000) begin
      step();
      guard++;
    end
    chk("drain_bound", 32'(guard < 5000), 32'(1));
    idle(2);
  endtask

  initial begin
    int k;
    int k0;
    int pe;
    int ce;
    int idx;
    int guard;
    int r;

    dif.s_axis_tvalid = 1'b0;
    dif.s_axis_tdata  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_putchar",   32'(dif.o_putchar),    32'(0));
    chk("rst_clearhome", 32'(dif.o_clearhome),  32'(0));
    chk("rst_char",      32'(dif.o_char),       32'(8'h00));
    chk("rst_level",     32'(dif.o_level),      32'(0));
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_tready", 32'(dif.s_axis_tready), 32'(1));

    // Single character into an empty queue
    clear_obs();
    push_byte(8'h41);
    k = acc_edge;
    drain();
    pe = (obs_put_edge.size() > 0) ? obs_put_edge[0] : -1;
    chk("A_count",   32'(obs_put_edge.size()), 32'(1));
    chk("A_latency", 32'(pe - k),              32'(1));
    chk("A_char",    32'((obs_char.size() > 0) ? obs_char[0] : 8'hFF), 32'(8'h41));
    chk("A_level",   32'(dif.o_level),         32'(0));

    // Two characters back-to-back: spacing CHAR_GAP+1
    clear_obs();
    push_byte(8'h48);
    push_byte(8'h49);
    drain();
    chk("HI_count", 32'(obs_put_edge.size()), 32'(2));
    if (obs_put_edge.size() == 2) begin
      chk("HI_spacing", 32'(obs_put_edge[1] - obs_put_edge[0]), 32'(CHAR_GAP + 1));
      chk("HI_char0",   32'(obs_char[0]), 32'(8'h48));
      chk("HI_char1",   32'(obs_char[1]), 32'(8'h49));
    end
    chk("HI_hold", 32'(dif.o_char), 32'(8'h49));

    // Form-feed then character: clear-home, then putchar CLEAR_GAP+1 later
    clear_obs();
    push_byte(8'h0C);
    k = acc_edge;
    push_byte(8'h58);
    drain();
    ce = (obs_clr_edge.size() > 0) ? obs_clr_edge[0] : -1;
    pe = (obs_put_edge.size() > 0) ? obs_put_edge[0] : -1;
    chk("FF_clr_count", 32'(obs_clr_edge.size()), 32'(1));
    chk("FF_put_count", 32'(obs_put_edge.size()), 32'(1));
    chk("FF_latency",   32'(ce - k),  32'(1));
    chk("FF_spacing",   32'(pe - ce), 32'(CLEAR_GAP + 1));
    chk("FF_char",      32'(dif.o_char), 32'(8'h58));

    // NUL bytes are dropped but each costs one cycle
    clear_obs();
    push_byte(8'h5A);
    k = acc_edge;
    drain();
    pe = (obs_put_edge.size() > 0) ? obs_put_edge[0] : -1;
    chk("Z_bare_latency", 32'(pe - k), 32'(1));
    clear_obs();
    push_byte(8'h00);
    k0 = acc_edge;
    push_byte(8'h00);
    push_byte(8'h5A);
    drain();
    pe = (obs_put_edge.size() > 0) ? obs_put_edge[0] : -1;
    chk("NUL_put_count", 32'(obs_put_edge.size()), 32'(1));
    chk("NUL_clr_count", 32'(obs_clr_edge.size()), 32'(0));
    chk("NUL_latency",   32'(pe - k0), 32'(3));

    // Continuous stream of 20 distinct bytes: fill, back-pressure, order
    clear_obs();
    dif.s_axis_tvalid = 1'b1;
    idx   = 0;
    guard = 0;
    while (idx < 20 && guard < 2000) begin
      dif.s_axis_tdata = 8'h60 + 8'(idx);
      step();
      if (acc_edge == edge_n) idx++;
      guard++;
    end
    dif.s_axis_tvalid = 1'b0;
    chk("stream_bound", 32'(guard < 2000), 32'(1));
    drain();
    chk("stream_count", 32'(obs_char.size()), 32'(20));
    chk("stream_full",  32'(max_level), 32'(DEPTH));
    chk("stream_stall", 32'(stall_cnt > 0), 32'(1));
    for (int j = 0; j < 20; j++) begin
      chk("stream_order", 32'((j < obs_char.size()) ? obs_char[j] : 8'hFF), 32'(8'h60 + j));
    end

    // Asynchronous reset in the middle of a wait with bytes queued
    clear_obs();
    for (int j = 0; j < 5; j++) push_byte(8'h41 + 8'(j));
    idle(3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_putchar",   32'(dif.o_putchar),   32'(0));
    chk("arst_clearhome", 32'(dif.o_clearhome), 32'(0));
    chk("arst_char",      32'(dif.o_char),      32'(8'h00));
    chk("arst_level",     32'(dif.o_level),     32'(0));
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    clear_obs();
    idle(30);
    chk("arst_silent", 32'(obs_put_edge.size() + obs_clr_edge.size()), 32'(0));
    push_byte(8'h51);
    k = acc_edge;
    drain();
    pe = (obs_put_edge.size() > 0) ? obs_put_edge[0] : -1;
    chk("arst_fresh_latency", 32'(pe - k), 32'(1));
    chk("arst_fresh_char",    32'(dif.o_char), 32'(8'h51));

    // Random traffic against the model
    clear_obs();
    for (int j = 0; j < 400; j++) begin
      dif.s_axis_tvalid = ($urandom_range(0, 2) != 0);
      r = int'($urandom_range(0, 9));
      if (r == 0)      dif.s_axis_tdata = 8'h00;
      else if (r == 1) dif.s_axis_tdata = 8'h0C;
      else             dif.s_axis_tdata = 8'($urandom_range(8'h20, 8'h7E));
      step();
    end
    dif.s_axis_tvalid = 1'b0;
    drain();
    chk("rand_empty", 32'(dif.o_level), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
